// File: rtl/sqrt_fpu_frontend.sv
// Front end for the lampFPU square-root core. It unpacks and classifies the operand and
// issues it to the core, then normalizes, rounds (RNE) and packs the core's result.
module sqrt_fpu_frontend (
  input  logic        clk,
  input  logic        rst,
  input  logic        doOp_i,
  input  logic [15:0] op_i,
  input  logic        invSqrt_i,
  output logic        doSqrt_o,
  output logic [7:0]  s_o,
  output logic        is_exp_odd_o,
  output logic        invSqrt_o,
  output logic        special_case_o,
  input  logic        sqrt_valid_i,
  input  logic [15:0] sqrt_res_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [15:0] res_o,
  output logic [2:0]  flags_o,
  output logic [1:0]  dbg_state
);
  localparam int LAMP_FLOAT_DW   = 16;
  localparam int LAMP_FLOAT_E_DW = 8;
  localparam int LAMP_FLOAT_F_DW = 7;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ROUND} state_t;
  state_t state, state_nxt;

  // Handshake: a request is taken on any cycle where doOp_i=1 and the FSM is in IDLE
  // or in ROUND (the valid_o cycle). The core answers once per doSqrt_o pulse with a
  // one-cycle sqrt_valid_i, which is only honoured in WAIT.
  logic accept;
  assign accept = doOp_i && (state == IDLE || state == ROUND);

  logic                       op_sign;
  logic [LAMP_FLOAT_E_DW-1:0] op_exp;
  logic [LAMP_FLOAT_F_DW-1:0] op_frac;
  logic op_zero, op_inf, op_nan, op_neg, op_special;
  assign op_sign    = op_i[LAMP_FLOAT_DW-1];
  assign op_exp     = op_i[LAMP_FLOAT_DW-2:LAMP_FLOAT_F_DW];
  assign op_frac    = op_i[LAMP_FLOAT_F_DW-1:0];
  assign op_zero    = (op_exp == '0);
  assign op_inf     = (op_exp == '1) && (op_frac == '0);
  assign op_nan     = (op_exp == '1) && (op_frac != '0);
  assign op_neg     = op_sign && !op_zero && !op_nan;
  assign op_special = op_zero || op_inf || op_nan || op_neg;

  // Subnormals land in op_zero, so they flush to a signed zero here.
  logic [15:0] spec_res_nxt;
  logic [2:0]  spec_flags_nxt;
  always_comb begin
    spec_res_nxt   = 16'h0000;
    spec_flags_nxt = 3'b000;
    if (op_nan) begin
      spec_res_nxt = 16'h7FC0;
    end else if (op_neg) begin
      spec_res_nxt   = 16'h7FC0;
      spec_flags_nxt = 3'b100;
    end else if (op_zero) begin
      if (invSqrt_i) begin
        spec_res_nxt   = {op_sign, 8'hFF, 7'h00};
        spec_flags_nxt = 3'b010;
      end else begin
        spec_res_nxt = {op_sign, 15'h0000};
      end
    end else if (op_inf) begin
      spec_res_nxt = invSqrt_i ? 16'h0000 : 16'h7F80;
    end
  end

  // k = floor(e/2); the result exponent is 127 +/- k before normalization.
  logic signed [8:0] unb_exp, half_exp;
  logic [7:0]        exp_base_nxt;
  assign unb_exp      = $signed({1'b0, op_exp}) - 9'sd127;
  assign half_exp     = unb_exp >>> 1;
  assign exp_base_nxt = invSqrt_i ? 8'(9'sd127 - half_exp) : 8'(9'sd127 + half_exp);

  logic [7:0]  exp_base;
  logic [15:0] spec_res;
  logic [2:0]  spec_flags;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_o            <= '0;
      is_exp_odd_o   <= 1'b0;
      invSqrt_o      <= 1'b0;
      special_case_o <= 1'b0;
      exp_base       <= '0;
      spec_res       <= '0;
      spec_flags     <= '0;
    end else if (accept) begin
      s_o            <= op_special ? 8'h00 : {1'b1, op_frac};
      is_exp_odd_o   <= op_special ? 1'b0 : unb_exp[0];
      invSqrt_o      <= invSqrt_i;
      special_case_o <= op_special;
      exp_base       <= exp_base_nxt;
      spec_res       <= spec_res_nxt;
      spec_flags     <= spec_flags_nxt;
    end
  end

  // Normalize [0.5,2) to [1,2), then round to nearest even on the 7-bit fraction.
  logic [15:0] norm;
  logic [7:0]  exp_n, exp_r, frac_r;
  logic [6:0]  frac;
  logic        guard, sticky, round_up;
  assign norm     = sqrt_res_i[15] ? sqrt_res_i : {sqrt_res_i[14:0], 1'b0};
  assign exp_n    = sqrt_res_i[15] ? exp_base : exp_base - 8'd1;
  assign frac     = norm[14:8];
  assign guard    = norm[7];
  assign sticky   = |norm[6:0];
  assign round_up = guard && (sticky || frac[0]);
  assign frac_r   = {1'b0, frac} + {7'd0, round_up};
  assign exp_r    = exp_n + {7'd0, frac_r[7]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_o   <= '0;
      flags_o <= '0;
    end else if (state == WAIT && sqrt_valid_i) begin
      res_o   <= special_case_o ? spec_res : {1'b0, exp_r, frac_r[6:0]};
      flags_o <= special_case_o ? spec_flags : {2'b00, guard | sticky};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (sqrt_valid_i) state_nxt = ROUND;
      ROUND:   state_nxt = accept ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    doSqrt_o  = (state == ISSUE);
    busy_o    = (state != IDLE);
    valid_o   = (state == ROUND);
    dbg_state = state;
  end
endmodule

// File: tb/tb_sqrt_fpu_frontend.sv
// Directed bench for sqrt_fpu_frontend: a driver plays operand source and square-root
// core, a monitor pops expected {res,flags} on every valid_o.
module tb_sqrt_fpu_frontend;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        doOp_i = 1'b0;
  logic [15:0] op_i = '0;
  logic        invSqrt_i = 1'b0;
  logic        doSqrt_o;
  logic [7:0]  s_o;
  logic        is_exp_odd_o, invSqrt_o, special_case_o;
  logic        sqrt_valid_i = 1'b0;
  logic [15:0] sqrt_res_i = '0;
  logic        busy_o, valid_o;
  logic [15:0] res_o;
  logic [2:0]  flags_o;
  logic [1:0]  dbg_state;

  logic [18:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  sqrt_fpu_frontend dut (
    .clk(clk), .rst(rst), .doOp_i(doOp_i), .op_i(op_i), .invSqrt_i(invSqrt_i),
    .doSqrt_o(doSqrt_o), .s_o(s_o), .is_exp_odd_o(is_exp_odd_o), .invSqrt_o(invSqrt_o),
    .special_case_o(special_case_o), .sqrt_valid_i(sqrt_valid_i), .sqrt_res_i(sqrt_res_i),
    .busy_o(busy_o), .valid_o(valid_o), .res_o(res_o), .flags_o(flags_o),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_doSqrt"}, doSqrt_o, 0);
    chk({tag, "_s"}, s_o, 0);
    chk({tag, "_odd"}, is_exp_odd_o, 0);
    chk({tag, "_inv"}, invSqrt_o, 0);
    chk({tag, "_special"}, special_case_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_valid"}, valid_o, 0);
    chk({tag, "_res"}, res_o, 0);
    chk({tag, "_flags"}, flags_o, 0);
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    #1;
    if (valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        chk("res", res_o, e[18:3]);
        chk("flags", flags_o, e[2:0]);
      end
    end
  end

  // Driver: issue one operation and play the core with latency lat (V = A+lat, lat>=2).
  task automatic run_op(input logic [15:0] op, input logic inv, input logic [15:0] cres,
                        input int lat, input logic [15:0] eres, input logic [2:0] eflg,
                        input logic [7:0] es, input logic eodd, input logic espec,
                        input logic b2b, input logic poke);
    if (!b2b) begin
      @(negedge clk);
      chk("idle_busy", busy_o, 0);
    end
    doOp_i = 1'b1; op_i = op; invSqrt_i = inv;
    exp_q.push_back({eres, eflg});
    @(negedge clk);
    doOp_i = 1'b0;
    chk("doSqrt_A1", doSqrt_o, 1);
    chk("busy_A1", busy_o, 1);
    chk("s", s_o, es);
    chk("odd", is_exp_odd_o, eodd);
    chk("special", special_case_o, espec);
    chk("inv_mode", invSqrt_o, inv);
    for (int i = 0; i < lat - 1; i++) begin
      if (poke && i == 0) begin
        doOp_i = 1'b1; op_i = 16'h4080; invSqrt_i = ~inv;
      end else begin
        doOp_i = 1'b0;
      end
      @(negedge clk);
      chk("doSqrt_wait", doSqrt_o, 0);
      chk("busy_wait", busy_o, 1);
      chk("valid_wait", valid_o, 0);
    end
    doOp_i = 1'b0; op_i = op; invSqrt_i = inv;
    sqrt_valid_i = 1'b1; sqrt_res_i = cres;
    @(negedge clk);
    sqrt_valid_i = 1'b0; sqrt_res_i = 16'hDEAD;
    chk("valid_V1", valid_o, 1);
    chk("busy_V1", busy_o, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // normal path: op, inv, core, lat, res, flags, s, odd, special, b2b, poke
    run_op(16'h4080, 0, 16'h8000, 3, 16'h4000, 3'b000, 8'h80, 0, 0, 0, 0);
    run_op(16'h4000, 0, 16'hB505, 4, 16'h3FB5, 3'b001, 8'h80, 1, 0, 0, 0);
    run_op(16'h4000, 1, 16'h5A82, 2, 16'h3F35, 3'b001, 8'h80, 1, 0, 0, 0);
    run_op(16'h4080, 1, 16'h8000, 2, 16'h3F00, 3'b000, 8'h80, 0, 0, 1, 0);
    run_op(16'h3F80, 0, 16'hFFC0, 3, 16'h4000, 3'b001, 8'h80, 0, 0, 0, 0);
    run_op(16'h3F80, 0, 16'h8080, 2, 16'h3F80, 3'b001, 8'h80, 0, 0, 0, 0);
    run_op(16'h3F80, 0, 16'h8180, 2, 16'h3F82, 3'b001, 8'h80, 0, 0, 0, 0);
    run_op(16'h3E80, 1, 16'h8000, 2, 16'h4000, 3'b000, 8'h80, 0, 0, 0, 0);
    run_op(16'h3E80, 0, 16'h8000, 2, 16'h3F00, 3'b000, 8'h80, 0, 0, 0, 0);
    run_op(16'h3F00, 0, 16'hB505, 2, 16'h3F35, 3'b001, 8'h80, 1, 0, 0, 0);
    // 12-cycle core latency with a doOp_i poke during WAIT
    run_op(16'h4120, 0, 16'hCA62, 12, 16'h404A, 3'b001, 8'hA0, 1, 0, 0, 1);

    // specials: core answers at A+2 with garbage data
    run_op(16'hC080, 0, 16'h1234, 2, 16'h7FC0, 3'b100, 8'h00, 0, 1, 0, 0);
    run_op(16'h0000, 1, 16'h1234, 2, 16'h7F80, 3'b010, 8'h00, 0, 1, 0, 0);
    run_op(16'h7F80, 1, 16'h1234, 2, 16'h0000, 3'b000, 8'h00, 0, 1, 1, 0);
    run_op(16'h7F80, 0, 16'h1234, 2, 16'h7F80, 3'b000, 8'h00, 0, 1, 0, 0);
    run_op(16'h0001, 0, 16'h1234, 2, 16'h0000, 3'b000, 8'h00, 0, 1, 0, 0);
    run_op(16'h8000, 0, 16'h1234, 2, 16'h8000, 3'b000, 8'h00, 0, 1, 0, 0);
    run_op(16'h8000, 1, 16'h1234, 2, 16'hFF80, 3'b010, 8'h00, 0, 1, 0, 0);
    run_op(16'hFF80, 1, 16'h1234, 2, 16'h7FC0, 3'b100, 8'h00, 0, 1, 0, 0);
    run_op(16'h7FC1, 0, 16'h1234, 2, 16'h7FC0, 3'b000, 8'h00, 0, 1, 0, 0);

    // spurious core valid while idle
    @(negedge clk);
    sqrt_valid_i = 1'b1; sqrt_res_i = 16'h8000;
    @(negedge clk);
    sqrt_valid_i = 1'b0;
    chk("spurious_valid", valid_o, 0);
    chk("spurious_busy", busy_o, 0);
    @(negedge clk);
    chk("spurious_valid2", valid_o, 0);

    // asynchronous reset in WAIT
    doOp_i = 1'b1; op_i = 16'h4080; invSqrt_i = 1'b0;
    @(negedge clk);
    doOp_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", busy_o, 1);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h4000, 0, 16'hB505, 5, 16'h3FB5, 3'b001, 8'h80, 1, 0, 0, 0);

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
